// File: rtl/hsid_x_obi_inf_pkg.sv
// OBI interface types shared by the arbiter, its routing FIFO and the
// surrounding fabric, plus the default arbiter sizing.
//   obi_req_t  : address-phase request (req, addr, we, be, wdata)
//   obi_resp_t : grant and response-phase return (gnt, rvalid, rdata)
package hsid_x_obi_inf_pkg;

  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;

  localparam int HSID_OBI_ARB_NUM_REQ   = 2;
  localparam int HSID_OBI_ARB_MAX_OUTST = 4;

  typedef struct packed {
    logic                    req;
    logic [OBI_ADDR_W-1:0]   addr;
    logic                    we;
    logic [OBI_DATA_W/8-1:0] be;
    logic [OBI_DATA_W-1:0]   wdata;
  } obi_req_t;

  typedef struct packed {
    logic                  gnt;
    logic                  rvalid;
    logic [OBI_DATA_W-1:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/hsid_x_obi_arb_fifo.sv
// Synchronous routing FIFO: remembers which manager owns each in-flight
// request so responses can be steered back in grant order.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push      : store push_data (ignored when full)
//   push_data : manager index to store
//   pop       : drop the head entry (ignored when empty)
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : number of stored entries
//   head      : oldest stored entry
module hsid_x_obi_arb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/hsid_x_obi_arb.sv
// Round-robin OBI arbiter: NUM_REQ managers share one subordinate port.
// The address phase is passed through combinationally; each handshake
// records the winning index in a routing FIFO, and responses are steered
// back to the FIFO head with zero latency.
//   clk, rst    : clock, synchronous active-high reset
//   m_obi_req   : per-manager requests
//   m_obi_rsp   : per-manager grant / response
//   s_obi_req   : request to the shared subordinate
//   s_obi_rsp   : grant / response from the shared subordinate
//   clear       : resets arbitration pointer and rsp_err when nothing is in flight
//   outstanding : in-flight request count
//   idle        : nothing in flight and no manager requesting
//   rsp_err     : sticky, set by an rvalid that matches no request
module hsid_x_obi_arb
  import hsid_x_obi_inf_pkg::*;
#(
  parameter int NUM_REQ   = HSID_OBI_ARB_NUM_REQ,
  parameter int MAX_OUTST = HSID_OBI_ARB_MAX_OUTST
) (
  input  logic                       clk,
  input  logic                       rst,
  input  obi_req_t                   m_obi_req [NUM_REQ],
  output obi_resp_t                  m_obi_rsp [NUM_REQ],
  output obi_req_t                   s_obi_req,
  input  obi_resp_t                  s_obi_rsp,
  input  logic                       clear,
  output logic [$clog2(MAX_OUTST):0] outstanding,
  output logic                       idle,
  output logic                       rsp_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  logic [IDX_W-1:0] last_granted;
  logic [IDX_W-1:0] lock_idx;
  logic             locked;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_found;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_req;
  logic             any_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [IDX_W-1:0] head_idx;
  logic             hs;
  logic             pop;
  logic             stray;
  logic             clear_ok;

  // Round-robin search starting just after the last granted index.
  always_comb begin
    int c;
    c        = 0;
    rr_found = 1'b0;
    rr_idx   = '0;
    any_req  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (int'(last_granted) + k) % NUM_REQ;
      if (!rr_found && m_obi_req[c].req) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(c);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      any_req = any_req | m_obi_req[i].req;
    end
  end

  // A request already offered to the subordinate but not yet granted keeps
  // the port until it is granted; the address phase must not change under it.
  always_comb begin
    if (locked && m_obi_req[lock_idx].req) begin
      sel_idx = lock_idx;
      sel_req = 1'b1;
    end else begin
      sel_idx = rr_idx;
      sel_req = rr_found;
    end
  end

  always_comb begin
    s_obi_req     = m_obi_req[sel_idx];
    s_obi_req.req = sel_req && !fifo_full && !rst;
  end

  assign hs       = s_obi_req.req && s_obi_rsp.gnt;
  assign pop      = s_obi_rsp.rvalid && !fifo_empty && !rst;
  assign stray    = s_obi_rsp.rvalid && fifo_empty && !rst;
  assign clear_ok = clear && fifo_empty;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      m_obi_rsp[i].gnt    = hs && (sel_idx == IDX_W'(i));
      m_obi_rsp[i].rvalid = pop && (head_idx == IDX_W'(i));
      m_obi_rsp[i].rdata  = s_obi_rsp.rdata;
    end
  end

  // A push is gated by fifo_full sampled at the start of the cycle, so a
  // same-cycle pop never makes room for a push.
  hsid_x_obi_arb_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (IDX_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (hs),
    .push_data (sel_idx),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (head_idx)
  );

  // Later assignments win: a handshake beats clear for the pointer, and a
  // stray response beats clear for the error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_granted <= IDX_W'(NUM_REQ - 1);
      locked       <= 1'b0;
      lock_idx     <= '0;
      rsp_err      <= 1'b0;
    end else begin
      if (clear_ok) begin
        last_granted <= IDX_W'(NUM_REQ - 1);
        rsp_err      <= 1'b0;
      end
      if (stray) rsp_err <= 1'b1;
      if (hs) begin
        last_granted <= sel_idx;
        locked       <= 1'b0;
      end else if (s_obi_req.req) begin
        locked   <= 1'b1;
        lock_idx <= sel_idx;
      end else begin
        locked <= 1'b0;
      end
    end
  end

  assign outstanding = fifo_count;
  assign idle        = fifo_empty && !any_req;

endmodule
